// File: rtl/triangle_stream_unpacker_if.sv
// Word-stream input and triangle output handshake bundle for triangle_stream_unpacker.
// slave is the unpacker's view; master is the loader/consumer side.
interface triangle_stream_unpacker_if #(
  parameter int WORD_W = 32,
  parameter int TRI_W  = 392
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [TRI_W-1:0]  tri_out;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, tri_out, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, tri_out, out_valid
  );
endinterface

// File: rtl/triangle_stream_unpacker.sv
// Reassembles 13-word frames from the scene-memory loader into packed triangle
// bits (word 0 at the LSBs), enforcing in_last framing with a sticky error flag.
module triangle_stream_unpacker #(
  parameter int WORD_W = 32,
  parameter int TRI_W  = 392,
  parameter int WORDS  = (TRI_W + WORD_W - 1) / WORD_W
) (
  input  logic                       clk,
  input  logic                       rst,
  triangle_stream_unpacker_if.slave  strm,
  output logic                       frame_err,
  input  logic                       err_clear,
  output logic [15:0]                tri_count
);

  // Only the low bits of the final word are meaningful.
  localparam int LAST_BITS = TRI_W - (WORDS - 1) * WORD_W;

  typedef enum logic [1:0] {
    COLLECT,
    HOLD,
    DISCARD
  } state_t;

  state_t     state, state_nx;
  logic [3:0] idx, idx_nx;
  logic       accept;
  logic       at_last;
  logic       wr_slice;
  logic       wr_final;
  logic       set_err;
  logic       handoff;

  assign accept        = strm.in_valid & strm.in_ready;
  assign at_last       = (idx == 4'(WORDS - 1));
  assign strm.in_ready = ~rst & (state != HOLD);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    wr_slice = 1'b0;
    wr_final = 1'b0;
    set_err  = 1'b0;
    handoff  = 1'b0;
    case (state)
      COLLECT: begin
        if (accept) begin
          if (!at_last) begin
            if (strm.in_last) begin
              set_err = 1'b1;
              idx_nx  = '0;
            end else begin
              wr_slice = 1'b1;
              idx_nx   = idx + 4'd1;
            end
          end else begin
            idx_nx = '0;
            if (strm.in_last) begin
              wr_final = 1'b1;
              state_nx = HOLD;
            end else begin
              set_err  = 1'b1;
              state_nx = DISCARD;
            end
          end
        end
      end
      HOLD: begin
        if (strm.out_ready) begin
          handoff  = 1'b1;
          state_nx = COLLECT;
        end
      end
      DISCARD: begin
        if (accept && strm.in_last) begin
          idx_nx   = '0;
          state_nx = COLLECT;
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Slices land straight in tri_out; writes only happen while out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strm.tri_out <= '0;
    end else begin
      if (wr_slice) begin
        for (int unsigned k = 0; k < WORDS - 1; k++) begin
          if (idx == 4'(k)) strm.tri_out[k*WORD_W +: WORD_W] <= strm.in_data;
        end
      end
      if (wr_final) strm.tri_out[TRI_W-1 -: LAST_BITS] <= strm.in_data[LAST_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strm.out_valid <= 1'b0;
      tri_count      <= '0;
      frame_err      <= 1'b0;
    end else begin
      if (wr_final)     strm.out_valid <= 1'b1;
      else if (handoff) strm.out_valid <= 1'b0;
      if (handoff) tri_count <= tri_count + 16'd1;
      // A new framing error outranks a simultaneous clear.
      if (set_err)        frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_triangle_stream_unpacker.sv
// Directed-plus-random bench for triangle_stream_unpacker against a frame-level
// reference model (word list -> packed triangle, framing rules as plain counting).
module tb_triangle_stream_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clear = 1'b0;
  logic        frame_err;
  logic [15:0] tri_count;

  triangle_stream_unpacker_if #(.WORD_W(32), .TRI_W(392)) bus ();

  triangle_stream_unpacker #(.WORD_W(32), .TRI_W(392)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .strm      (bus.slave),
    .frame_err (frame_err),
    .err_clear (err_clear),
    .tri_count (tri_count)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  logic [31:0]  wbuf [13];
  int unsigned  nwords = 0;
  bit           discarding = 1'b0;
  logic [391:0] exp_q [$];
  logic         exp_err = 1'b0;
  logic [15:0]  exp_count = 16'h0000;

  task automatic chk(input string tag, input logic [391:0] obs, input logic [391:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    nwords = 0;
    discarding = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_count = 16'h0000;
  endtask

  task automatic model_word(input logic [31:0] d, input logic l);
    if (discarding) begin
      if (l) discarding = 1'b0;
    end else begin
      wbuf[nwords] = d;
      nwords++;
      if (l) begin
        if (nwords == 13)
          exp_q.push_back({wbuf[12][7:0], wbuf[11], wbuf[10], wbuf[9], wbuf[8], wbuf[7],
                           wbuf[6], wbuf[5], wbuf[4], wbuf[3], wbuf[2], wbuf[1], wbuf[0]});
        else
          exp_err = 1'b1;
        nwords = 0;
      end else if (nwords == 13) begin
        exp_err = 1'b1;
        discarding = 1'b1;
        nwords = 0;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send(input logic [31:0] d, input logic l, input bit allow_gap);
    int unsigned n = 0;
    if (allow_gap && $urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      bus.in_last  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (n < 50) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=in_ready_low expected=accept");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model_word(d, l);
  endtask

  task automatic send_frame(input logic [31:0] base, input bit rnd);
    for (int k = 0; k < 13; k++)
      send(rnd ? 32'($urandom) : base + 32'(k), k == 12, rnd);
  endtask

  // Called right after the 13th accept; stalls the consumer, then hands off.
  task automatic expect_frame(input int stall);
    logic [391:0] exp;
    exp = (exp_q.size() > 0) ? exp_q[0] : 'x;
    bus.out_ready = (stall == 0);
    @(negedge clk);
    chk("out_valid_rise", 392'(bus.out_valid), 392'(1'b1));
    chk("tri_out", bus.tri_out, exp);
    chk("in_ready_hold", 392'(bus.in_ready), 392'(1'b0));
    if (stall > 0) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_last  = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("stall_valid", 392'(bus.out_valid), 392'(1'b1));
        chk("stall_tri", bus.tri_out, exp);
        chk("stall_in_ready", 392'(bus.in_ready), 392'(1'b0));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    exp_count = exp_count + 16'd1;
    chk("handoff_valid", 392'(bus.out_valid), 392'(1'b0));
    chk("tri_count", 392'(tri_count), 392'(exp_count));
    chk("in_ready_after", 392'(bus.in_ready), 392'(1'b1));
    chk("frame_err", 392'(frame_err), 392'(exp_err));
    chk("tri_out_retained", bus.tri_out, exp);
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    exp_err = 1'b0;
    chk("err_cleared", 392'(frame_err), 392'(1'b0));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 392'(bus.in_ready), 392'(1'b0));
    chk("rst_out_valid", 392'(bus.out_valid), 392'(1'b0));
    chk("rst_tri_out", bus.tri_out, '0);
    chk("rst_frame_err", 392'(frame_err), 392'(1'b0));
    chk("rst_tri_count", 392'(tri_count), 392'(16'h0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_idle", 392'(bus.in_ready), 392'(1'b1));

    // Basic frame with fixed words
    send_frame(32'h1000_0000, 1'b0);
    expect_frame(0);
    chk("color_b", 392'(bus.tri_out[15:0]), 392'(16'h0000));
    chk("color_g", 392'(bus.tri_out[31:16]), 392'(16'h1000));
    chk("v0x_top", 392'(bus.tri_out[391:384]), 392'(8'h0C));

    // Output backpressure
    send_frame(32'h0, 1'b1);
    expect_frame(5);

    // Early last on word 5
    for (int k = 0; k < 6; k++) send(32'($urandom), k == 5, 1'b0);
    @(negedge clk);
    chk("early_err", 392'(frame_err), 392'(exp_err));
    chk("early_no_valid", 392'(bus.out_valid), 392'(1'b0));
    @(posedge clk); #1;
    clear_err();
    send_frame(32'h0, 1'b1);
    expect_frame(1);

    // Missing last: 13 words without last, then 3 more ending with last
    for (int k = 0; k < 16; k++) send(32'($urandom), k == 15, 1'b1);
    @(negedge clk);
    chk("missing_err", 392'(frame_err), 392'(exp_err));
    chk("missing_no_valid", 392'(bus.out_valid), 392'(1'b0));
    chk("missing_count", 392'(tri_count), 392'(exp_count));
    @(posedge clk); #1;
    clear_err();
    send_frame(32'h0, 1'b1);
    expect_frame(0);

    // Async reset mid-frame
    for (int k = 0; k < 7; k++) send(32'($urandom), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_in_ready", 392'(bus.in_ready), 392'(1'b0));
    chk("arst_tri_out", bus.tri_out, '0);
    chk("arst_count", 392'(tri_count), 392'(exp_count));
    chk("arst_out_valid", 392'(bus.out_valid), 392'(1'b0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send_frame(32'h0, 1'b1);
    expect_frame(2);

    // Randomized frames with random consumer stalls
    for (int f = 0; f < 6; f++) begin
      send_frame(32'h0, 1'b1);
      expect_frame($urandom_range(0, 3));
    end

    // Counter wrap
    @(negedge clk);
    force u_dut.tri_count = 16'hFFFE;
    @(posedge clk); #1;
    release u_dut.tri_count;
    exp_count = 16'hFFFE;
    chk("count_preload", 392'(tri_count), 392'(exp_count));
    send_frame(32'h0, 1'b1);
    expect_frame(0);
    send_frame(32'h0, 1'b1);
    expect_frame(0);
    chk("count_wrapped", 392'(tri_count), 392'(16'h0000));

    // Set wins over a coincident clear, then a lone clear takes effect
    send(32'($urandom), 1'b0, 1'b0);
    send(32'($urandom), 1'b0, 1'b0);
    err_clear = 1'b1;
    send(32'($urandom), 1'b1, 1'b0);
    err_clear = 1'b0;
    chk("set_wins", 392'(frame_err), 392'(exp_err));
    clear_err();
    send_frame(32'h0, 1'b1);
    expect_frame(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/triangle_stream_unpacker.md
# triangle_stream_unpacker

Deserializes a 32-bit word stream, produced by the scene-memory loader, into packed `triangle` structs from `data_structs` and hands them to the intersection pipeline over a valid/ready interface. It is the receive end of the triangle flattening the host performs when writing scene memory. It also enforces per-triangle framing: each triangle is exactly 13 words, with `in_last` on the 13th.

## Interface
Parameters:
- `WORD_W`, 32: input word width. Only 32 is supported.
- `TRI_W`, `$bits(triangle)` = 392: triangle width in bits.
- `WORDS`, `(TRI_W+WORD_W-1)/WORD_W` = 13: words per triangle.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  32  stream word.
- `in_valid`  in  1  word valid.
- `in_last`  in  1  marks final word of a triangle.
- `in_ready`  out  1  block accepts a word this cycle.
- `tri_out`  out  392 (`triangle`)  assembled triangle, registered.
- `out_valid`  out  1  `tri_out` valid.
- `out_ready`  in  1  consumer accepts.
- `frame_err`  out  1  sticky framing-error flag.
- `err_clear`  in  1  clears `frame_err`.
- `tri_count`  out  16  count of triangles handed off; wraps.

## Operation
- **Bit mapping:** word k (k = 0..12) supplies `tri[32k+31:32k]`.
  - Word 0 is the struct LSBs: `{color.g, color.b}`.
  - Word 12 uses bits [7:0] only, which land on `tri[391:384]` (top of `v0.x`). Bits [31:8] of word 12 are ignored.
- **Accept rule:** a word is accepted when `in_valid & in_ready`.
- **States:** COLLECT, HOLD, DISCARD. A 4-bit index `idx` counts words.
- **COLLECT** (`in_ready`=1). On each accepted word:
  - If `idx` < 12 and `in_last`=0: write the slice, `idx`++.
  - If `idx` < 12 and `in_last`=1 (early last): set `frame_err`, drop the partial triangle, `idx`←0, stay in COLLECT.
  - If `idx` = 12 and `in_last`=1: write the slice into `tri_out`, `out_valid`←1, `idx`←0, go to HOLD.
  - If `idx` = 12 and `in_last`=0 (missing last): set `frame_err`, `idx`←0, go to DISCARD.
- **HOLD** (`in_ready`=0, `out_valid`=1).
  - On `out_ready`: `out_valid`←0, `tri_count`++, go to COLLECT.
  - `tri_out` holds its value after handoff until it is next overwritten.
- **DISCARD** (`in_ready`=1): drop accepted words. On an accepted word with `in_last`=1, go to COLLECT with `idx`=0.
- **Slice writes:** assembled directly into the `tri_out` register. Slices are written only while `out_valid`=0, so the consumer never sees partial updates while valid.
- **`frame_err`:** set by either framing error above; cleared by `err_clear`. If a set and a clear land in the same cycle, set wins.
- **`tri_count`:** 16-bit, wraps 0xFFFF→0x0000.

## Timing
- **Reset values** (while `rst` is high, asynchronously): state COLLECT, `idx`=0, `tri_out`=0, `out_valid`=0, `frame_err`=0, `tri_count`=0, `in_ready`=0. `in_ready` is gated by `rst`.
- **`in_ready`:** a combinational decode of state: 1 in COLLECT/DISCARD, 0 in HOLD. It does not depend on `in_valid`.
- **Output latency:** `out_valid` rises the cycle after the 13th word is accepted.
- **Throughput:** peak 1 triangle per 14 cycles (13 accepts + 1 HOLD cycle when `out_ready` is held high).
- **Handshake rules:**
  - `out_valid` and `tri_out` stay stable until `out_ready` is sampled high.
  - The source may present `in_valid` with `in_ready`=0; the word is not consumed.
- **Reset mid-frame:** partial data is discarded. The first word after reset release is treated as word 0.

## Test plan
- **Basic frame.** Send 13 words, word k = 0x1000_0000+k, `in_last` on word 12, `out_ready`=1.
  - Expect `out_valid` one cycle after the 13th accept.
  - Expect `color.b`=0x0000, `color.g`=0x1000, `material`=0x00, `v0.x[27:20]`=0x0C.
  - Expect `tri_count`=1 and `frame_err`=0.
- **Output backpressure.** Hold `out_ready`=0 for 5 cycles after `out_valid`.
  - Expect `out_valid`=1, `tri_out` unchanged, `in_ready`=0 throughout.
  - On release: handoff in 1 cycle, `tri_count`++, `in_ready`=1 the next cycle.
- **Early last.** Set `in_last` on word 5.
  - Expect `frame_err`=1 and no `out_valid`.
  - A following clean 13-word frame is emitted with correct mapping.
- **Missing last.** Send 13 words with no `in_last`, then 3 more words with `in_last` on the 3rd.
  - Expect `frame_err`=1 and all 16 words dropped.
  - The next clean frame is emitted correctly.
- **Async reset mid-frame.** Assert `rst` after 7 words, between clock edges.
  - Expect outputs to go to reset values immediately and `in_ready`=0 during reset.
  - A fresh 13-word frame after release is emitted correctly.
- **Counter wrap and error-flag priority.**
  - Preload `tri_count` to 0xFFFF via 65535 frames (or force) → the next handoff gives 0x0000.
  - `err_clear` coincident with an early-`in_last` error → `frame_err` stays 1.
  - A later `err_clear` alone → `frame_err` goes to 0.
